// File: rtl/rv_iommu_ds_pkg.sv
// ============================================================================
// Module      : rv_iommu_ds_pkg
// Description : Shared definitions for the IOMMU data-structure (DS) AXI port.
//               Holds the read/write requester index maps, the default
//               requester count, and the default AR/R channel payload types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_iommu_ds_pkg;

  // Read-side requester indices. The index doubles as the AXI ID on the DS bus.
  localparam int unsigned DS_RD_PTW    = 0;
  localparam int unsigned DS_RD_CDW    = 1;
  localparam int unsigned DS_RD_CQ     = 2;
  localparam int unsigned DS_RD_MSIPTW = 3;
  localparam int unsigned DS_RD_MRIF   = 4;
  localparam int unsigned DS_RD_NUM    = 5;

  // Write-side requester indices.
  localparam int unsigned DS_WR_FQ     = 0;
  localparam int unsigned DS_WR_CQ     = 1;
  localparam int unsigned DS_WR_MRIF   = 2;
  localparam int unsigned DS_WR_NUM    = 3;

  localparam int unsigned DS_ID_WIDTH  = 4;

  typedef struct packed {
    logic [DS_ID_WIDTH-1:0] id;
    logic [55:0]            addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
  } ds_ar_chan_t;

  typedef struct packed {
    logic [DS_ID_WIDTH-1:0] id;
    logic [63:0]            data;
    logic [1:0]             resp;
    logic                   last;
  } ds_r_chan_t;

endpackage

`default_nettype wire

// File: rtl/rv_iommu_ds_rr_sel.sv
// ============================================================================
// Module      : rv_iommu_ds_rr_sel
// Description : Combinational round-robin pick. Grants the first eligible
//               requester at or after rr_ptr, searching cyclically.
// Ports       : eligible  - per-requester eligibility
//               rr_ptr    - index the search starts from
//               gnt       - one-hot grant
//               gnt_idx   - binary index of the grant
//               gnt_valid - some requester was granted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_iommu_ds_rr_sel #(
  parameter int unsigned NumReq = 5,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] eligible,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_valid
);

  int unsigned w_j;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_j       = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_j = (32'(rr_ptr) + k) % NumReq;
      if (!gnt_valid && eligible[w_j]) begin
        gnt_valid  = 1'b1;
        gnt[w_j]   = 1'b1;
        gnt_idx    = IdxW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_iommu_ds_rd_sched.sv
// ============================================================================
// Module      : rv_iommu_ds_rd_sched
// Description : Read-side scheduler for the IOMMU DS AXI port. Round-robin AR
//               arbitration with per-requester outstanding limits, requester
//               index stamped as AXI ID, R beats routed back by ID, and
//               unattributable R beats drained and flagged.
// Ports       : clk_i, rst_ni            - clock, synchronous active-low reset
//               req_ar_* / req_r_*       - requester-side AR and R channels
//               mst_ar_* / mst_r_*       - DS bus AR and R channels
//               busy_o                   - AR staged or reads outstanding
//               unexp_r_o                - drained unattributable R beat
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_iommu_ds_rd_sched
  import rv_iommu_ds_pkg::*;
#(
  parameter int unsigned NumReq         = DS_RD_NUM,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned IdWidth        = DS_ID_WIDTH,
  parameter type         ar_chan_t      = ds_ar_chan_t,
  parameter type         r_chan_t       = ds_r_chan_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  ar_chan_t [NumReq-1:0]   req_ar_i,
  input  logic     [NumReq-1:0]   req_ar_valid_i,
  output logic     [NumReq-1:0]   req_ar_ready_o,
  output r_chan_t                 req_r_o,
  output logic     [NumReq-1:0]   req_r_valid_o,
  input  logic     [NumReq-1:0]   req_r_ready_i,
  output ar_chan_t                mst_ar_o,
  output logic                    mst_ar_valid_o,
  input  logic                    mst_ar_ready_i,
  input  r_chan_t                 mst_r_i,
  input  logic                    mst_r_valid_i,
  output logic                    mst_r_ready_o,
  output logic                    busy_o,
  output logic                    unexp_r_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] c_max_out = CntW'(MaxOutstanding);

  logic                   r_ar_valid;
  ar_chan_t               r_ar;
  logic [CntW-1:0]        r_cnt [NumReq];
  logic [IdxW-1:0]        r_rr_ptr;

  logic [NumReq-1:0]      w_elig;
  logic [NumReq-1:0]      w_gnt;
  logic [IdxW-1:0]        w_gnt_idx;
  logic                   w_gnt_valid;
  logic                   w_stage_free;
  logic                   w_up_hs;
  ar_chan_t               w_ar_load;
  logic [IdWidth-1:0]     w_id_ext;
  logic [NumReq-1:0]      w_r_hit;
  logic                   w_r_attr;
  logic [NumReq-1:0]      w_inc;
  logic [NumReq-1:0]      w_dec;
  logic [NumReq-1:0]      w_cnt_nz;

  // ---------------------------------------------------------------- AR side
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign w_cnt_nz[gi] = (r_cnt[gi] != '0);
    assign w_elig[gi]   = req_ar_valid_i[gi] & (r_cnt[gi] < c_max_out);
    assign w_inc[gi]    = w_up_hs & w_gnt[gi];
    // Only an attributed beat can retire a read, so counts cannot underflow.
    assign w_dec[gi]    = w_r_hit[gi] & mst_r_valid_i & req_r_ready_i[gi] & mst_r_i.last;
  end

  rv_iommu_ds_rr_sel #(
    .NumReq (NumReq)
  ) u_rr_sel (
    .eligible  (w_elig),
    .rr_ptr    (r_rr_ptr),
    .gnt       (w_gnt),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  // A full stage that is being popped this cycle can accept the next grant,
  // which keeps back-to-back throughput at one AR per cycle.
  assign w_stage_free   = ~r_ar_valid | mst_ar_ready_i;
  assign w_up_hs        = w_gnt_valid & w_stage_free;
  assign req_ar_ready_o = w_gnt & {NumReq{w_stage_free}};
  assign w_id_ext       = IdWidth'(w_gnt_idx);

  always_comb begin
    w_ar_load = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_gnt[i]) w_ar_load = req_ar_i[i];
    end
    w_ar_load.id = w_id_ext;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ar_valid <= 1'b0;
      r_ar       <= '0;
      r_rr_ptr   <= '0;
    end else if (w_up_hs) begin
      r_ar_valid <= 1'b1;
      r_ar       <= w_ar_load;
      r_rr_ptr   <= (w_gnt_idx == IdxW'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (mst_ar_ready_i) begin
      r_ar_valid <= 1'b0;
    end
  end

  assign mst_ar_o       = r_ar;
  assign mst_ar_valid_o = r_ar_valid;

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!rst_ni) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i]) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- R side
  // A beat belongs to a requester only if its ID names one that has a read in
  // flight; anything else is drained so it cannot stall the DS bus.
  always_comb begin
    w_r_hit = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if ((mst_r_i.id == IdWidth'(i)) && (r_cnt[i] != '0)) w_r_hit[i] = 1'b1;
    end
    w_r_attr      = |w_r_hit;
    req_r_valid_o = w_r_hit & {NumReq{mst_r_valid_i}};
    mst_r_ready_o = w_r_attr ? |(w_r_hit & req_r_ready_i) : 1'b1;
    unexp_r_o     = mst_r_valid_i & ~w_r_attr;
  end

  assign req_r_o = mst_r_i;
  assign busy_o  = r_ar_valid | (|w_cnt_nz);

endmodule

`default_nettype wire

// File: tb/tb_rv_iommu_ds_rd_sched.sv
// ============================================================================
// Module      : tb_rv_iommu_ds_rd_sched
// Description : Self-checking bench for rv_iommu_ds_rd_sched. A cycle model
//               predicts ready/valid/busy/unexp each cycle; expected AR
//               payloads are queued on predicted grants and popped on DS bus
//               AR handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rv_iommu_ds_rd_sched;
  import rv_iommu_ds_pkg::*;

  localparam int N = 5;
  localparam int MAXO = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  ds_ar_chan_t [N-1:0]    req_ar;
  logic [N-1:0]           req_ar_valid;
  logic [N-1:0]           req_ar_ready;
  ds_r_chan_t             req_r;
  logic [N-1:0]           req_r_valid;
  logic [N-1:0]           req_r_ready;
  ds_ar_chan_t            mst_ar;
  logic                   mst_ar_valid;
  logic                   mst_ar_ready;
  ds_r_chan_t             mst_r;
  logic                   mst_r_valid;
  logic                   mst_r_ready;
  logic                   busy;
  logic                   unexp;

  always #5 clk = ~clk;

  rv_iommu_ds_rd_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_ar_i       (req_ar),
    .req_ar_valid_i (req_ar_valid),
    .req_ar_ready_o (req_ar_ready),
    .req_r_o        (req_r),
    .req_r_valid_o  (req_r_valid),
    .req_r_ready_i  (req_r_ready),
    .mst_ar_o       (mst_ar),
    .mst_ar_valid_o (mst_ar_valid),
    .mst_ar_ready_i (mst_ar_ready),
    .mst_r_i        (mst_r),
    .mst_r_valid_i  (mst_r_valid),
    .mst_r_ready_o  (mst_r_ready),
    .busy_o         (busy),
    .unexp_r_o      (unexp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------- model
  ds_ar_chan_t sb[$];
  int          popped_ids[$];
  int          unexp_seen = 0;
  int          m_cnt [N];
  int          m_ptr = 0;
  bit          m_sv  = 0;
  bit          m_free;
  int          m_g;
  int          m_rid;
  bit          m_attr;
  bit          m_busy;
  logic [N-1:0] m_rdy;
  logic [N-1:0] m_rv;
  ds_ar_chan_t m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_sv  = 0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      sb.delete();
    end else begin
      m_free = !m_sv || mst_ar_ready;
      m_g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_g < 0 && req_ar_valid[j] && m_cnt[j] < MAXO) m_g = j;
      end
      m_rdy = '0;
      if (m_g >= 0 && m_free) m_rdy[m_g] = 1'b1;
      m_busy = m_sv;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) m_busy = 1;

      chk("ar_ready", req_ar_ready, m_rdy);
      chk("ar_valid", mst_ar_valid, m_sv);
      chk("busy", busy, m_busy);
      if (m_sv && sb.size() > 0) chk("ar_payload", mst_ar, sb[0]);

      m_rid  = int'(mst_r.id);
      m_attr = (m_rid < N) && (m_cnt[m_rid % N] != 0);
      m_rv   = '0;
      if (m_attr && mst_r_valid) m_rv[m_rid] = 1'b1;
      chk("r_valid", req_r_valid, m_rv);
      chk("r_ready", mst_r_ready, m_attr ? req_r_ready[m_rid % N] : 1'b1);
      chk("unexp", unexp, mst_r_valid && !m_attr);
      chk("r_payload", req_r, mst_r);
      if (unexp) unexp_seen++;

      if (mst_ar_valid && mst_ar_ready) begin
        popped_ids.push_back(int'(mst_ar.id));
        if (sb.size() > 0) void'(sb.pop_front());
        else chk("sb_underflow", 1, 0);
      end
      if (m_sv && mst_ar_ready) m_sv = 0;
      if (m_g >= 0 && m_free) begin
        m_e    = req_ar[m_g];
        m_e.id = 4'(m_g);
        sb.push_back(m_e);
        m_cnt[m_g]++;
        m_ptr = (m_g + 1) % N;
        m_sv  = 1;
      end
      if (m_attr && mst_r_valid && req_r_ready[m_rid] && mst_r.last) m_cnt[m_rid]--;
    end
  end

  // --------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input int id, input bit last, input logic [N-1:0] rdy);
    mst_r_valid = 1'b1;
    mst_r.id    = 4'(id);
    mst_r.last  = last;
    mst_r.data  = {$urandom, $urandom};
    mst_r.resp  = 2'b00;
    req_r_ready = rdy;
    cyc(1);
    mst_r_valid = 1'b0;
    mst_r       = '0;
    req_r_ready = '0;
  endtask

  initial begin
    int exp_ids [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    int u0;
    rst_n        = 1'b0;
    req_ar_valid = '0;
    req_r_ready  = '0;
    mst_ar_ready = 1'b0;
    mst_r        = '0;
    mst_r_valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_ar[i].id    = 4'hF;
      req_ar[i].addr  = 56'h1000 * 56'(i + 1);
      req_ar[i].len   = 8'(i);
      req_ar[i].size  = 3'd3;
      req_ar[i].burst = 2'b01;
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_ar_valid", mst_ar_valid, 0);
    chk("rst_ar_payload", mst_ar, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ar_ready", req_ar_ready, 0);
    chk("rst_unexp", unexp, 0);

    // Fairness: all requesters valid, bus always ready.
    popped_ids.delete();
    mst_ar_ready = 1'b1;
    req_ar_valid = 5'h1F;
    cyc(13);
    chk("fair_saturated_ready", req_ar_ready, 0);
    req_ar_valid = '0;
    cyc(2);
    chk("fair_count", popped_ids.size(), 10);
    for (int k = 0; k < 10 && k < popped_ids.size(); k++)
      chk($sformatf("fair_id%0d", k), popped_ids[k], exp_ids[k]);
    for (int i = 0; i < N; i++) begin
      r_beat(i, 1'b1, 5'h1F);
      r_beat(i, 1'b1, 5'h1F);
    end
    cyc(1);
    chk("fair_drain_busy", busy, 0);

    // Backpressure with a full stage.
    mst_ar_ready = 1'b0;
    req_ar_valid = 5'b00011;
    cyc(1);
    cyc(4);
    chk("bp_ready", req_ar_ready, 0);
    chk("bp_id", mst_ar.id, 0);
    mst_ar_ready = 1'b1;
    cyc(1);
    chk("bp_next_valid", mst_ar_valid, 1);
    chk("bp_next_id", mst_ar.id, 1);
    req_ar_valid = '0;
    cyc(2);
    r_beat(0, 1'b1, 5'h1F);
    r_beat(1, 1'b1, 5'h1F);
    cyc(1);
    chk("bp_drain_busy", busy, 0);

    // Outstanding limit on CDW.
    req_ar_valid = 5'b00010;
    cyc(4);
    chk("lim_cdw_blocked", req_ar_ready[1], 0);
    req_ar_valid = 5'b00011;
    #1;
    chk("lim_ptw_proceeds", req_ar_ready, 5'b00001);
    cyc(1);
    req_ar_valid = 5'b00010;
    r_beat(1, 1'b1, 5'h1F);
    chk("lim_cdw_reopen", req_ar_ready[1], 1);
    cyc(1);
    req_ar_valid = '0;
    cyc(1);
    r_beat(1, 1'b1, 5'h1F);
    r_beat(1, 1'b1, 5'h1F);
    r_beat(0, 1'b1, 5'h1F);
    cyc(1);
    chk("lim_drain_busy", busy, 0);

    // R burst routing to CQ with toggling ready.
    req_ar_valid = 5'b00100;
    cyc(1);
    req_ar_valid = '0;
    cyc(2);
    u0 = unexp_seen;
    for (int b = 0; b < 3; b++) begin
      mst_r_valid = 1'b1;
      mst_r.id    = 4'd2;
      mst_r.last  = (b == 2);
      mst_r.data  = 64'(b);
      req_r_ready = 5'b11011;
      cyc(1);
      req_r_ready = 5'b00100;
      cyc(1);
    end
    mst_r_valid = 1'b0;
    mst_r       = '0;
    req_r_ready = '0;
    cyc(1);
    chk("burst_busy", busy, 0);
    chk("burst_no_unexp", unexp_seen - u0, 0);

    // Unexpected R beats.
    u0 = unexp_seen;
    r_beat(7, 1'b1, 5'h00);
    r_beat(0, 1'b1, 5'h00);
    cyc(1);
    chk("unexp_pulses", unexp_seen - u0, 2);
    chk("unexp_busy", busy, 0);

    // Issue and retire on MSI PTW in the same cycle.
    req_ar_valid = 5'b01000;
    cyc(1);
    req_ar_valid = '0;
    cyc(1);
    req_ar_valid = 5'b01000;
    r_beat(3, 1'b1, 5'h1F);
    cyc(1);
    #1;
    chk("sim_cap", req_ar_ready[3], 0);
    req_ar_valid = '0;
    cyc(1);
    r_beat(3, 1'b1, 5'h1F);
    r_beat(3, 1'b1, 5'h1F);
    cyc(1);
    chk("sim_busy", busy, 0);

    // Reset in the middle of a burst.
    req_ar_valid = 5'h1F;
    cyc(3);
    rst_n        = 1'b0;
    req_ar_valid = '0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_ar_valid", mst_ar_valid, 0);
    chk("mid_rst_ar_payload", mst_ar, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ar_ready, 0);
    u0 = unexp_seen;
    r_beat(0, 1'b1, 5'h1F);
    r_beat(1, 1'b1, 5'h1F);
    cyc(1);
    chk("mid_rst_drained", unexp_seen - u0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
